// File: rtl/score_pkg.sv
// Shared definitions for the score binary-to-BCD path and the digit renderer.
// Holds the converter state encoding, score geometry and the digit index width
// that the renderer uses as its bitmap ROM row offset.
package score_pkg;

    localparam int unsigned SCORE_DIGITS      = 4;
    localparam int unsigned SCORE_BIN_W       = 14;
    localparam int unsigned SCORE_MAX         = 9999;
    localparam int unsigned SCORE_DIGIT_IDX_W = $clog2(SCORE_DIGITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/score_bin2bcd_if.sv
// Request/result bundle between the score source and score_bin2bcd.
// master: drives start/in, observes ready, done_tick, bcd3..bcd0 (and overflow).
// slave : the converter side.
// Optional macro SCORE_CLAMP_EN adds the overflow flag.
interface score_bin2bcd_if #(
    parameter int unsigned BIN_W = score_pkg::SCORE_BIN_W
);
    logic             start;
    logic [BIN_W-1:0] in;
    logic             ready;
    logic             done_tick;
    logic [3:0]       bcd3;
    logic [3:0]       bcd2;
    logic [3:0]       bcd1;
    logic [3:0]       bcd0;
`ifdef SCORE_CLAMP_EN
    logic             overflow;

    modport master (output start, in,
                    input  ready, done_tick, bcd3, bcd2, bcd1, bcd0, overflow);
    modport slave  (input  start, in,
                    output ready, done_tick, bcd3, bcd2, bcd1, bcd0, overflow);
`else
    modport master (output start, in,
                    input  ready, done_tick, bcd3, bcd2, bcd1, bcd0);
    modport slave  (input  start, in,
                    output ready, done_tick, bcd3, bcd2, bcd1, bcd0);
`endif
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
// Ports: d - working digit in, q - corrected digit out (combinational).
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? (d + 4'd3) : d;
endmodule

// File: rtl/score_bin2bcd.sv
// Sequential binary-to-BCD converter feeding the score digit renderer.
// One double-dabble iteration per clock; digit outputs only change on the
// edge that completes a conversion, so the display never shows partial values.
// Ports: clk, reset (sync, active-high), bus (slave side of score_bin2bcd_if:
//        start/in request, ready, done_tick, bcd3..bcd0 result).
// Optional macro SCORE_CLAMP_EN: inputs above 9999 clamp to 9999 and raise
// a registered overflow flag; otherwise the result wraps modulo 10000.
module score_bin2bcd
    import score_pkg::*;
#(
    parameter int unsigned BIN_W = SCORE_BIN_W
) (
    input  logic              clk,
    input  logic              reset,
    score_bin2bcd_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned BCD_W = 4 * SCORE_DIGITS;

    state_t           state;
    logic [CNT_W-1:0] n;
    logic [BIN_W-1:0] bin_reg;
    logic [BCD_W-1:0] bcd_work;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_next;
    logic [BCD_W-1:0] bcd_out;
    logic [BIN_W-1:0] load_val;

    // Per-digit +3 correction ahead of the shift
    for (genvar i = 0; i < SCORE_DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (bcd_work[4*i +: 4]),
            .q (bcd_adj[4*i +: 4])
        );
    end

    // Post-shift digits; the carry out of the top digit is dropped
    assign bcd_next = {bcd_adj[BCD_W-2:0], bin_reg[BIN_W-1]};

`ifdef SCORE_CLAMP_EN
    logic over_c;
    logic overflow;

    assign over_c   = (bus.in > BIN_W'(SCORE_MAX));
    assign load_val = over_c ? BIN_W'(SCORE_MAX) : bus.in;

    // Overflow flag follows each accepted request
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            overflow <= over_c;
        end
    end

    assign bus.overflow = overflow;
`else
    assign load_val = bus.in;
`endif

    // Conversion FSM, iteration counter, shift register and digit outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            n        <= '0;
            bin_reg  <= '0;
            bcd_work <= '0;
            bcd_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin_reg  <= load_val;
                        bcd_work <= '0;
                        n        <= CNT_W'(BIN_W);
                        state    <= OP;
                    end
                end
                OP: begin
                    bcd_work <= bcd_next;
                    bin_reg  <= {bin_reg[BIN_W-2:0], 1'b0};
                    n        <= n - CNT_W'(1);
                    if (n == CNT_W'(1)) begin
                        bcd_out <= bcd_next;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = (state == IDLE);
    assign bus.done_tick = (state == DONE);
    assign bus.bcd3      = bcd_out[15:12];
    assign bus.bcd2      = bcd_out[11:8];
    assign bus.bcd1      = bcd_out[7:4];
    assign bus.bcd0      = bcd_out[3:0];

endmodule

// File: tb/tb_score_bin2bcd.sv
// Self-checking bench for score_bin2bcd: vector table, random values against
// a decimal-arithmetic model, and hand-written timing/corner sequences.
module tb_score_bin2bcd;
    import score_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    score_bin2bcd_if #(.BIN_W(14)) bus ();

    score_bin2bcd #(.BIN_W(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int unsigned val;
        logic [15:0] exp_wrap;
        logic [15:0] exp_clamp;
    } vec_t;

    function automatic logic [15:0] cur_bcd();
        return {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
    endfunction

    // Expected four-digit result from plain decimal arithmetic
    function automatic logic [15:0] model(input int unsigned v);
        int unsigned r;
`ifdef SCORE_CLAMP_EN
        r = (v > 9999) ? 9999 : v;
`else
        r = v % 10000;
`endif
        return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one conversion starting at a negedge; returns result and latency
    task automatic convert(input logic [13:0] v, output logic [15:0] res, output int lat);
        logic [15:0] prev;
        bit          hold_ok;
        int          w;
        w = 0;
        while (!bus.ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_start", 32'(bus.ready), 32'd1);
        prev      = cur_bcd();
        bus.start = 1'b1;
        bus.in    = v;
        @(negedge clk);
        bus.start = 1'b0;
        hold_ok   = 1'b1;
        lat       = -1;
        res       = 'x;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.done_tick) begin
                lat = k;
                res = cur_bcd();
                break;
            end
            if (cur_bcd() !== prev) hold_ok = 1'b0;
            if (bus.ready) hold_ok = 1'b0;
        end
        check("digits_hold_busy", 32'(hold_ok), 32'd1);
        check("latency", 32'(lat), 32'd14);
        check("ready_low_in_done", 32'(bus.ready), 32'd0);
        @(negedge clk);
        check("ready_after_done", 32'(bus.ready), 32'd1);
        check("done_single_cycle", 32'(bus.done_tick), 32'd0);
    endtask

    initial begin
        vec_t        vecs [12];
        logic [15:0] res;
        logic [15:0] exp;
        int          lat;
        int          pulses;
        int unsigned rv;

        vecs[0]  = '{0,     16'h0000, 16'h0000};
        vecs[1]  = '{1234,  16'h1234, 16'h1234};
        vecs[2]  = '{9999,  16'h9999, 16'h9999};
        vecs[3]  = '{10,    16'h0010, 16'h0010};
        vecs[4]  = '{16383, 16'h6383, 16'h9999};
        vecs[5]  = '{50,    16'h0050, 16'h0050};
        vecs[6]  = '{1,     16'h0001, 16'h0001};
        vecs[7]  = '{99,    16'h0099, 16'h0099};
        vecs[8]  = '{100,   16'h0100, 16'h0100};
        vecs[9]  = '{10000, 16'h0000, 16'h9999};
        vecs[10] = '{8191,  16'h8191, 16'h8191};
        vecs[11] = '{5005,  16'h5005, 16'h5005};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.in    = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done_tick), 32'd0);
        check("rst_digits", 32'(cur_bcd()), 32'h0);
`ifdef SCORE_CLAMP_EN
        check("rst_overflow", 32'(bus.overflow), 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Vector table
        foreach (vecs[i]) begin
`ifdef SCORE_CLAMP_EN
            exp = vecs[i].exp_clamp;
`else
            exp = vecs[i].exp_wrap;
`endif
            convert(14'(vecs[i].val), res, lat);
            check($sformatf("vec_%0d", vecs[i].val), 32'(res), 32'(exp));
`ifdef SCORE_CLAMP_EN
            check($sformatf("ovf_%0d", vecs[i].val), 32'(bus.overflow),
                  32'(vecs[i].val > 9999));
`endif
        end

        // Back-to-back with start held high: accepts at E0 and E16
        bus.start = 1'b1;
        bus.in    = 14'd9999;
        @(negedge clk);
        bus.in = 14'd10;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done_tick) pulses++;
            if (k == 14) begin
                check("b2b_first_done", 32'(bus.done_tick), 32'd1);
                check("b2b_first_val", 32'(cur_bcd()), 32'h9999);
            end
            if (k == 30) begin
                check("b2b_second_done", 32'(bus.done_tick), 32'd1);
                check("b2b_second_val", 32'(cur_bcd()), 32'h0010);
                bus.start = 1'b0;
            end
        end
        check("b2b_pulses", 32'(pulses), 32'd2);

        // Start during a conversion is ignored
        bus.start = 1'b1;
        bus.in    = 14'd42;
        @(negedge clk);
        bus.start = 1'b0;
        pulses    = 0;
        res       = 'x;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.done_tick) begin
                pulses++;
                res = cur_bcd();
            end
            if (k == 4) begin
                bus.start = 1'b1;
                bus.in    = 14'd777;
            end
            if (k == 5) bus.start = 1'b0;
        end
        check("ignore_val", 32'(res), 32'h0042);
        check("ignore_pulses", 32'(pulses), 32'd1);

        // Reset mid-conversion aborts without a done pulse
        bus.start = 1'b1;
        bus.in    = 14'd4321;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_digits", 32'(cur_bcd()), 32'h0);
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_done", 32'(bus.done_tick), 32'd0);
        reset  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done_tick) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        convert(14'd4321, res, lat);
        check("after_abort_val", 32'(res), 32'h4321);

        // Random values against the decimal model
        for (int i = 0; i < 30; i++) begin
            rv = $urandom_range(16383, 0);
            convert(14'(rv), res, lat);
            check($sformatf("rand_%0d", rv), 32'(res), 32'(model(rv)));
`ifdef SCORE_CLAMP_EN
            check($sformatf("rand_ovf_%0d", rv), 32'(bus.overflow), 32'(rv > 9999));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
